// File: rtl/muldiv_iter.sv
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative RV32M/RV64M multiply/divide unit with valid/ready
//               handshakes, one result bit per cycle on operand magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] in_a_i,
    input  logic [XLEN-1:0] in_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int              C_CNT_W    = $clog2(XLEN);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] C_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CALC = 2'd1;
    localparam logic [1:0] C_FIX  = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    logic [1:0]          r_state_q, w_state_d;
    logic [C_CNT_W-1:0]  r_cnt_q;
    logic [2*XLEN-1:0]   r_acc_q;
    logic [XLEN-1:0]     r_opd_q;
    logic [2:0]          r_op_q;
    logic                r_sa_q, r_sb_q;
    logic [XLEN-1:0]     r_result_q;

    // Request decode
    logic            w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_special_res;

    assign w_a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    assign w_b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    assign w_sa       = w_a_signed & in_a_i[XLEN-1];
    assign w_sb       = w_b_signed & in_b_i[XLEN-1];
    assign w_abs_a    = w_sa ? -in_a_i : in_a_i;
    assign w_abs_b    = w_sb ? -in_b_i : in_b_i;
    assign w_b_zero   = (in_b_i == '0);
    assign w_ovf      = ((op_i == 3'd4) || (op_i == 3'd6)) && (in_a_i == C_MIN) && (&in_b_i);
    assign w_special  = op_i[2] & (w_b_zero | w_ovf);

    always_comb begin
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = op_i[1] ? in_a_i : '1;
        end else begin
            w_special_res = op_i[1] ? '0 : C_MIN;
        end
    end

    // Shared XLEN+1 adder: shift-add for multiply, trial subtract for divide
    logic            w_mul;
    logic [XLEN:0]   w_add_a, w_add_b, w_sum;
    logic            w_add_c;
    logic [2*XLEN-1:0] w_acc_next;

    assign w_mul = ~r_op_q[2];

    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_add_c = 1'b0;
        if (w_mul) begin
            w_add_a = {1'b0, r_acc_q[2*XLEN-1:XLEN]};
            w_add_b = r_acc_q[0] ? {1'b0, r_opd_q} : '0;
        end else begin
            w_add_a = r_acc_q[2*XLEN-1:XLEN-1];
            w_add_b = ~{1'b0, r_opd_q};
            w_add_c = 1'b1;
        end
    end

    assign w_sum = w_add_a + w_add_b + {{XLEN{1'b0}}, w_add_c};

    // Divide: w_sum[XLEN] set means the trial subtract borrowed
    always_comb begin
        w_acc_next = r_acc_q;
        if (w_mul) begin
            w_acc_next = {w_sum, r_acc_q[XLEN-1:1]};
        end else if (w_sum[XLEN]) begin
            w_acc_next = {r_acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            w_acc_next = {w_sum[XLEN-1:0], r_acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction of the magnitude result
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_fix_res;

    assign w_prod = (r_sa_q ^ r_sb_q) ? -r_acc_q : r_acc_q;
    assign w_quot = (r_sa_q ^ r_sb_q) ? -r_acc_q[XLEN-1:0] : r_acc_q[XLEN-1:0];
    assign w_rem  = r_sa_q ? -r_acc_q[2*XLEN-1:XLEN] : r_acc_q[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = '0;
        case (r_op_q)
            3'd0:                 w_fix_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:     w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:           w_fix_res = w_quot;
            default:              w_fix_res = w_rem;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= C_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_d = r_state_q;
        if (flush_i) begin
            w_state_d = C_IDLE;
        end else begin
            case (r_state_q)
                C_IDLE:  if (in_valid_i) w_state_d = w_special ? C_DONE : C_CALC;
                C_CALC:  if (r_cnt_q == C_CNT_LAST) w_state_d = C_FIX;
                C_FIX:   w_state_d = C_DONE;
                default: if (out_ready_i) w_state_d = C_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready_o  = (r_state_q == C_IDLE);
        out_valid_o = (r_state_q == C_DONE);
    end

    assign result_o = r_result_q;

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q    <= '0;
            r_acc_q    <= '0;
            r_opd_q    <= '0;
            r_op_q     <= '0;
            r_sa_q     <= 1'b0;
            r_sb_q     <= 1'b0;
            r_result_q <= '0;
        end else if (flush_i) begin
            r_cnt_q <= '0;
        end else begin
            case (r_state_q)
                C_IDLE: begin
                    if (in_valid_i) begin
                        r_op_q  <= op_i;
                        r_sa_q  <= w_sa;
                        r_sb_q  <= w_sb;
                        r_cnt_q <= '0;
                        if (w_special) begin
                            r_result_q <= w_special_res;
                        end else if (op_i[2]) begin
                            r_acc_q <= {{XLEN{1'b0}}, w_abs_a};
                            r_opd_q <= w_abs_b;
                        end else begin
                            r_acc_q <= {{XLEN{1'b0}}, w_abs_b};
                            r_opd_q <= w_abs_a;
                        end
                    end
                end
                C_CALC: begin
                    r_acc_q <= w_acc_next;
                    r_cnt_q <= r_cnt_q + C_CNT_W'(1);
                end
                C_FIX: begin
                    r_result_q <= w_fix_res;
                    r_cnt_q    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
